// File: rtl/cpu_prog_sequencer_if.sv
// CPU-side port bundle of the program sequencer: manual-load, instruction,
// mode and overflow lines. The sequencer is the master; the CPU is the slave.
interface cpu_prog_sequencer_if;
    logic [31:0] INS;
    logic [31:0] ManIn;
    logic [2:0]  RSM;
    logic        WR;
    logic        LO;
    logic        OV;

    modport master (output INS, output ManIn, output RSM, output WR, output LO, input OV);
    modport slave  (input INS, input ManIn, input RSM, input WR, input LO, output OV);
endinterface

// File: rtl/cpu_prog_sequencer.sv
// Stores a short LOAD/EXEC program and plays it into the CPU one entry per clock,
// with a bubble on each load/operate mode change. Optional OV halt: SEQ_OV_HALT_EN.
module cpu_prog_sequencer #(
    parameter int AW = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  prog_we,
    input  logic [AW-1:0]         prog_addr,
    input  logic [35:0]           prog_wdata,
    input  logic [AW:0]           prog_len,
    input  logic                  start,
    cpu_prog_sequencer_if.master  cpu,
    output logic                  busy,
    output logic                  done,
`ifdef SEQ_OV_HALT_EN
    output logic                  ov_abort,
`endif
    output logic [2:0]            state_dbg
);
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [AW:0]   LEN_MAX = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   IDX_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SWITCH, S_ISSUE, S_DONE} state_t;

    state_t        state;
    logic [35:0]   mem [DEPTH];
    logic [35:0]   rdata;
    logic [35:0]   cur;
    logic [AW:0]   len_q;
    logic [AW:0]   idx;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic          start_ok;
    logic          last;
    logic          halt;
    logic          wr_q;
    logic          lo_q;
    logic [2:0]    rsm_q;
    logic [31:0]   manin_q;
    logic [31:0]   ins_q;

    // Handshake: start (and prog_we) is accepted on a rising edge only while busy=0;
    // busy rises on that edge and falls on the edge that ends the one-cycle done pulse.
    assign start_ok = start && !busy;
    assign last     = (idx == len_q - IDX_ONE);
    // Read-ahead: rdata always holds the entry after cur so kind changes are seen in time.
    assign rd_en    = start_ok || (state == S_FETCH) || ((state == S_ISSUE) && !last && !halt);
    assign rd_addr  = start_ok ? '0 : rd_ptr;

    assign cpu.WR    = wr_q;
    assign cpu.LO    = lo_q;
    assign cpu.RSM   = rsm_q;
    assign cpu.ManIn = manin_q;
    assign cpu.INS   = ins_q;
    assign state_dbg = state;

`ifdef SEQ_OV_HALT_EN
    // OV is judged against the EXEC entry currently on the outputs.
    assign halt = wr_q && lo_q && cpu.OV;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        ov_abort <= 1'b0;
        else if (halt)     ov_abort <= 1'b1;
        else if (start_ok) ov_abort <= 1'b0;
    end
`else
    logic unused_ov;
    assign unused_ov = cpu.OV;
    assign halt      = 1'b0;
`endif

    // Program memory: not reset; a same-edge write is not visible to the read.
    always_ff @(posedge clk) begin
        if (prog_we && !busy) mem[prog_addr] <= prog_wdata;
        if (rd_en)            rdata <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            wr_q    <= 1'b0;
            lo_q    <= 1'b0;
            rsm_q   <= '0;
            manin_q <= '0;
            ins_q   <= '0;
            cur     <= '0;
            len_q   <= '0;
            idx     <= '0;
            rd_ptr  <= '0;
        end else begin
            wr_q    <= 1'b0;
            rsm_q   <= '0;
            manin_q <= '0;
            ins_q   <= '0;
            done    <= 1'b0;
            if (done) busy <= 1'b0;
            if (halt) begin
                lo_q  <= 1'b0;
                done  <= 1'b1;
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_ok) begin
                            busy   <= 1'b1;
                            len_q  <= (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
                            idx    <= '0;
                            rd_ptr <= PTR_ONE;
                            state  <= (prog_len == '0) ? S_DONE : S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        cur    <= rdata;
                        rd_ptr <= rd_ptr + PTR_ONE;
                        state  <= (rdata[35] != lo_q) ? S_SWITCH : S_ISSUE;
                    end
                    S_SWITCH: begin
                        lo_q  <= cur[35];
                        state <= S_ISSUE;
                    end
                    S_ISSUE: begin
                        wr_q <= 1'b1;
                        lo_q <= cur[35];
                        if (cur[35]) begin
                            ins_q <= cur[31:0];
                        end else begin
                            rsm_q   <= cur[34:32];
                            manin_q <= cur[31:0];
                        end
                        if (last) begin
                            state <= S_DONE;
                        end else begin
                            cur    <= rdata;
                            idx    <= idx + IDX_ONE;
                            rd_ptr <= rd_ptr + PTR_ONE;
                            state  <= (rdata[35] != cur[35]) ? S_SWITCH : S_ISSUE;
                        end
                    end
                    S_DONE: begin
                        lo_q  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cpu_prog_sequencer.sv
// Directed bench for cpu_prog_sequencer: expected per-cycle CPU-port values are
// queued by the driver and popped by a negedge monitor while busy is high.
module tb_cpu_prog_sequencer;
    localparam int AW = 4;
    localparam int W  = 70;

    logic          clk = 1'b0;
    logic          reset;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [35:0]   prog_wdata;
    logic [AW:0]   prog_len;
    logic          start;
    logic          busy;
    logic          done;
    logic [2:0]    state_dbg;
`ifdef SEQ_OV_HALT_EN
    logic          ov_abort;
`endif

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic [W-1:0] exp_q[$];

    cpu_prog_sequencer_if cpu ();

    cpu_prog_sequencer #(.AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .prog_len   (prog_len),
        .start      (start),
        .cpu        (cpu),
        .busy       (busy),
        .done       (done),
`ifdef SEQ_OV_HALT_EN
        .ov_abort   (ov_abort),
`endif
        .state_dbg  (state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // packing {WR, LO, RSM, ManIn, INS, done}
    function automatic logic [W-1:0] pk(input logic wr, input logic lo, input logic [2:0] rsm,
                                        input logic [31:0] man, input logic [31:0] ins, input logic dn);
        return {wr, lo, rsm, man, ins, dn};
    endfunction

    function automatic logic [35:0] ld(input logic [2:0] rsm, input logic [31:0] d);
        return {1'b0, rsm, d};
    endfunction

    function automatic logic [35:0] ex(input logic [31:0] d);
        return {1'b1, 3'd0, d};
    endfunction

    task automatic exp_idle();                                 exp_q.push_back(pk(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0)); endtask
    task automatic exp_load(input logic [2:0] r, input logic [31:0] d); exp_q.push_back(pk(1'b1, 1'b0, r, d, 32'd0, 1'b0)); endtask
    task automatic exp_exec(input logic [31:0] d);             exp_q.push_back(pk(1'b1, 1'b1, 3'd0, 32'd0, d, 1'b0)); endtask
    task automatic exp_switch(input logic lo);                 exp_q.push_back(pk(1'b0, lo, 3'd0, 32'd0, 32'd0, 1'b0)); endtask
    task automatic exp_done();                                 exp_q.push_back(pk(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1)); endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] want;
        if (mon_en) begin
            act = {cpu.WR, cpu.LO, cpu.RSM, cpu.ManIn, cpu.INS, done};
            checks++;
            if (busy === 1'b1) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL seq_unexpected got %h want nothing", act);
                end else begin
                    want = exp_q.pop_front();
                    if (act !== want) begin
                        errors++;
                        $display("FAIL seq got %h want %h", act, want);
                    end
                end
            end else if ({cpu.WR, done} !== 2'b00) begin
                errors++;
                $display("FAIL idle_quiet got WR=%b done=%b want 0 0", cpu.WR, done);
            end
        end
    end

    // driver tasks
    task automatic write_entry(input logic [AW-1:0] a, input logic [35:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_wdata = d;
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    task automatic pulse_start(input logic [AW:0] len);
        @(negedge clk);
        prog_len = len; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic start_with_write(input logic [AW:0] len, input logic [AW-1:0] a, input logic [35:0] d);
        @(negedge clk);
        prog_len = len; start = 1'b1;
        prog_we = 1'b1; prog_addr = a; prog_wdata = d;
        @(posedge clk); #1;
        start = 1'b0; prog_we = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check({name, "_finished"}, W'(busy), W'(0));
        check({name, "_drained"}, W'(exp_q.size()), W'(0));
        check({name, "_lo_load"}, W'(cpu.LO), W'(0));
    endtask

    task automatic wait_cpu(input string name, input logic [31:0] ins, input logic [2:0] rsm, input logic lo);
        int n;
        n = 0;
        while (!(cpu.WR === 1'b1 && cpu.LO === lo && cpu.INS === ins && cpu.RSM === rsm) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_reached"}, W'(n < 100), W'(1));
    endtask

    initial begin
        int n;
        reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        prog_len = '0; start = 1'b0; cpu.OV = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cpu_outputs", {cpu.WR, cpu.LO, cpu.RSM, cpu.ManIn, cpu.INS, done}, W'(0));
        check("reset_busy", W'(busy), W'(0));
        check("reset_state", W'(state_dbg), W'(0));
`ifdef SEQ_OV_HALT_EN
        check("reset_ov_abort", W'(ov_abort), W'(0));
`endif
        @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;

        // basic playback: three preloads, one bubble, four instructions
        write_entry(4'd0, ld(3'd0, 32'd51));
        write_entry(4'd1, ld(3'd1, 32'd32));
        write_entry(4'd2, ld(3'd2, 32'd0));
        write_entry(4'd3, ex(32'h3003_0002));
        write_entry(4'd4, ex(32'h1004_0003));
        write_entry(4'd5, ex(32'h1005_0102));
        write_entry(4'd6, ex(32'h2006_0405));
        exp_idle(); exp_idle();
        exp_load(3'd0, 32'd51); exp_load(3'd1, 32'd32); exp_load(3'd2, 32'd0);
        exp_switch(1'b1);
        exp_exec(32'h3003_0002); exp_exec(32'h1004_0003); exp_exec(32'h1005_0102); exp_exec(32'h2006_0405);
        exp_done();
        pulse_start(5'd7);
        wait_idle("basic");

        // rerun with reg2 preload all-ones; a write while busy must be dropped
        write_entry(4'd2, ld(3'd2, 32'hffff_ffff));
        exp_idle(); exp_idle();
        exp_load(3'd0, 32'd51); exp_load(3'd1, 32'd32); exp_load(3'd2, 32'hffff_ffff);
        exp_switch(1'b1);
        exp_exec(32'h3003_0002); exp_exec(32'h1004_0003); exp_exec(32'h1005_0102); exp_exec(32'h2006_0405);
        exp_done();
        pulse_start(5'd7);
        write_entry(4'd0, ld(3'd6, 32'h0bad_0bad));
        wait_idle("rerun");

        // single entry shows entry 0 unchanged
        exp_idle(); exp_idle(); exp_load(3'd0, 32'd51); exp_done();
        pulse_start(5'd1);
        wait_idle("len1");

        // empty program, then a start that lands on the done cycle
        exp_idle(); exp_done();
        pulse_start(5'd0);
        n = 0;
        while (done !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("len0_done_seen", W'(done), W'(1));
        prog_len = 5'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("start_on_done_ignored", W'(busy), W'(0));
        check("len0_drained", W'(exp_q.size()), W'(0));
        check("len0_lo", W'(cpu.LO), W'(0));

        // mixed kinds, including a bubble before an EXEC entry 0
        write_entry(4'd0, ex(32'ha5a5_0001));
        write_entry(4'd1, ld(3'd5, 32'h1234_5678));
        write_entry(4'd2, ex(32'ha5a5_0002));
        exp_idle(); exp_idle();
        exp_switch(1'b1); exp_exec(32'ha5a5_0001);
        exp_switch(1'b0); exp_load(3'd5, 32'h1234_5678);
        exp_switch(1'b1); exp_exec(32'ha5a5_0002);
        exp_done();
        pulse_start(5'd3);
        wait_idle("mixed");

        // write to entry 0 on the start edge: old entry 0 plays, new one next time
        exp_idle(); exp_idle(); exp_switch(1'b1); exp_exec(32'ha5a5_0001); exp_done();
        start_with_write(5'd1, 4'd0, ld(3'd7, 32'hdead_beef));
        wait_idle("same_edge_addr0");
        exp_idle(); exp_idle(); exp_load(3'd7, 32'hdead_beef); exp_done();
        pulse_start(5'd1);
        wait_idle("after_addr0_write");

        // write to entry 1 on the start edge is seen by this run
        exp_idle(); exp_idle(); exp_load(3'd7, 32'hdead_beef);
        exp_switch(1'b1); exp_exec(32'h0bad_f00d); exp_done();
        start_with_write(5'd2, 4'd1, ex(32'h0bad_f00d));
        wait_idle("same_edge_addr1");

        // full memory, length above the depth clamps to every entry once
        for (int i = 0; i < 16; i++) write_entry(4'(i), ld(3'(i % 8), 32'h100 + 32'(i * 7)));
        exp_idle(); exp_idle();
        for (int i = 0; i < 16; i++) exp_load(3'(i % 8), 32'h100 + 32'(i * 7));
        exp_done();
        pulse_start(5'd17);
        wait_idle("clamp");

        // async reset during entry 2, then a fresh replay from entry 0
        exp_idle(); exp_idle();
        for (int i = 0; i < 16; i++) exp_load(3'(i % 8), 32'h100 + 32'(i * 7));
        exp_done();
        pulse_start(5'd16);
        wait_cpu("entry2", 32'd0, 3'd2, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("midrun_reset_outputs", {cpu.WR, cpu.LO, cpu.RSM, cpu.ManIn, cpu.INS, done}, W'(0));
        check("midrun_reset_busy", W'(busy), W'(0));
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_idle", W'(state_dbg), W'(0));
        exp_idle(); exp_idle();
        exp_load(3'd0, 32'h100); exp_load(3'd1, 32'h107); exp_load(3'd2, 32'h10e);
        exp_done();
        pulse_start(5'd3);
        wait_idle("replay");

        for (int i = 0; i < 4; i++) write_entry(4'(i), ex(32'he000_0000 + 32'(i)));
`ifdef SEQ_OV_HALT_EN
        // OV during EXEC entry 1 stops the program
        exp_idle(); exp_idle(); exp_switch(1'b1);
        exp_exec(32'he000_0000); exp_exec(32'he000_0001);
        exp_done();
        pulse_start(5'd4);
        wait_cpu("exec1", 32'he000_0001, 3'd0, 1'b1);
        cpu.OV = 1'b1;
        @(negedge clk);
        cpu.OV = 1'b0;
        wait_idle("ov_halt");
        check("ov_abort_set", W'(ov_abort), W'(1));
        exp_idle(); exp_done();
        pulse_start(5'd0);
        wait_idle("after_ov");
        check("ov_abort_cleared", W'(ov_abort), W'(0));
`else
        // OV has no effect in this build
        cpu.OV = 1'b1;
        exp_idle(); exp_idle(); exp_switch(1'b1);
        for (int i = 0; i < 4; i++) exp_exec(32'he000_0000 + 32'(i));
        exp_done();
        pulse_start(5'd4);
        wait_idle("ov_ignored");
        cpu.OV = 1'b0;
`endif

        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        check("final_drained", W'(exp_q.size()), W'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
